// File: rtl/io_key_dev_pkg.sv
// Shared definitions for the KEY/SW memory-mapped responder: register map,
// control-register bit positions and the per-group flag update rule.
package io_key_dev_pkg;

  localparam logic [15:0] IO_KDATA = 16'hFFF0;
  localparam logic [15:0] IO_SDATA = 16'hFFF2;
  localparam logic [15:0] IO_KCTRL = 16'hFFF4;
  localparam logic [15:0] IO_SCTRL = 16'hFFF6;

  localparam int unsigned CTRL_RDY = 0;
  localparam int unsigned CTRL_OVR = 1;
  localparam int unsigned CTRL_IE  = 4;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_KDATA,
    REG_SDATA,
    REG_KCTRL,
    REG_SCTRL
  } reg_sel_e;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic rdy;
  } ctrl_flags_t;

  // A change event always wins over a clear of RDY in the same cycle; a
  // change while RDY stays set means an unread value was lost.
  function automatic ctrl_flags_t ctrl_next(ctrl_flags_t cur, logic chg,
                                            logic rd_clr, logic wr,
                                            logic d_rdy, logic d_ovr,
                                            logic d_ie);
    ctrl_flags_t nxt;
    logic        rdy_clr;
    rdy_clr = rd_clr | (wr & ~d_rdy);
    nxt.rdy = chg | (cur.rdy & ~rdy_clr);
    nxt.ovr = (chg & cur.rdy & ~rdy_clr) | (cur.ovr & ~(wr & ~d_ovr));
    nxt.ie  = wr ? d_ie : cur.ie;
    return nxt;
  endfunction

  function automatic logic [7:0] ctrl_word(ctrl_flags_t f);
    logic [7:0] w;
    w           = '0;
    w[CTRL_RDY] = f.rdy;
    w[CTRL_OVR] = f.ovr;
    w[CTRL_IE]  = f.ie;
    return w;
  endfunction

endpackage

// File: rtl/io_key_dev_if.sv
// Data-memory bus view seen by an I/O responder: M-stage address, load/store
// strobes, store data, and combinational read data plus select.
interface io_key_dev_if #(
  parameter int unsigned DBITS = 16
) ();

  logic [DBITS-1:0] addr;
  logic             re;
  logic             we;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             sel;

  modport master (output addr, output re, output we, output din,
                  input dout, input sel);
  modport slave  (input addr, input re, input we, input din,
                  output dout, output sel);

endinterface

// File: rtl/io_key_dev_debounce_sync.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// only moves after the synced value has differed for DEBCYC consecutive edges.
module debounce_sync #(
  parameter int unsigned      WIDTH  = 4,
  parameter int unsigned      DEBCYC = 100000,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam int unsigned         CNT_W    = $clog2(DEBCYC);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBCYC - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // changed is the edge-coincident strobe: high in the cycle whose edge
  // loads the new level, so consumers update on the same edge.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    changed = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        changed = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RSTVAL;
      sync2_q <= RSTVAL;
      level_q <= RSTVAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/io_key_dev.sv
// KEY/SW responder on the data-memory bus: debounced data registers, per-group
// RDY/OVR/IE control registers, combinational read mux and registered irq.
module io_key_dev
  import io_key_dev_pkg::*;
#(
  parameter int unsigned DBITS  = 16,
  parameter int unsigned DEBCYC = 100000,
  parameter int unsigned KBITS  = 4,
  parameter int unsigned SBITS  = 10
) (
  input  logic             clk,
  input  logic             reset,
  io_key_dev_if.slave      bus,
  input  logic [KBITS-1:0] key,
  input  logic [SBITS-1:0] sw,
  output logic             irq
);

  logic [KBITS-1:0] k_level;
  logic [SBITS-1:0] s_level;
  logic             k_changed, s_changed;
  reg_sel_e         reg_sel;
  ctrl_flags_t      kflags_q, kflags_d;
  ctrl_flags_t      sflags_q, sflags_d;
  logic             irq_q, irq_d;
  logic             k_rd_clr, s_rd_clr, k_wr, s_wr;
  logic             unused_din;

  // Keys are active-low, so they rest at all-ones.
  debounce_sync #(
    .WIDTH  (KBITS),
    .DEBCYC (DEBCYC),
    .RSTVAL ({KBITS{1'b1}})
  ) u_key_deb (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (key),
    .level   (k_level),
    .changed (k_changed)
  );

  debounce_sync #(
    .WIDTH  (SBITS),
    .DEBCYC (DEBCYC),
    .RSTVAL ({SBITS{1'b0}})
  ) u_sw_deb (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (sw),
    .level   (s_level),
    .changed (s_changed)
  );

  always_comb begin
    reg_sel = REG_NONE;
    if      (bus.addr == DBITS'(IO_KDATA)) reg_sel = REG_KDATA;
    else if (bus.addr == DBITS'(IO_SDATA)) reg_sel = REG_SDATA;
    else if (bus.addr == DBITS'(IO_KCTRL)) reg_sel = REG_KCTRL;
    else if (bus.addr == DBITS'(IO_SCTRL)) reg_sel = REG_SCTRL;
  end

  assign bus.sel = (reg_sel != REG_NONE);

  always_comb begin
    bus.dout = '0;
    case (reg_sel)
      REG_KDATA: bus.dout = DBITS'(k_level);
      REG_SDATA: bus.dout = DBITS'(s_level);
      REG_KCTRL: bus.dout = DBITS'(ctrl_word(kflags_q));
      REG_SCTRL: bus.dout = DBITS'(ctrl_word(sflags_q));
      default:   bus.dout = '0;
    endcase
  end

  // Stores to DATA registers fall through here untouched.
  assign k_rd_clr = bus.re & (reg_sel == REG_KDATA);
  assign s_rd_clr = bus.re & (reg_sel == REG_SDATA);
  assign k_wr     = bus.we & (reg_sel == REG_KCTRL);
  assign s_wr     = bus.we & (reg_sel == REG_SCTRL);

  always_comb begin
    kflags_d = ctrl_next(kflags_q, k_changed, k_rd_clr, k_wr,
                         bus.din[CTRL_RDY], bus.din[CTRL_OVR], bus.din[CTRL_IE]);
    sflags_d = ctrl_next(sflags_q, s_changed, s_rd_clr, s_wr,
                         bus.din[CTRL_RDY], bus.din[CTRL_OVR], bus.din[CTRL_IE]);
    irq_d    = (kflags_q.rdy & kflags_q.ie) | (sflags_q.rdy & sflags_q.ie);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kflags_q <= '0;
      sflags_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      kflags_q <= kflags_d;
      sflags_q <= sflags_d;
      irq_q    <= irq_d;
    end
  end

  assign irq        = irq_q;
  assign unused_din = ^bus.din;

endmodule

// File: tb/tb_io_key_dev.sv
// Bench for io_key_dev with DEBCYC=4: directed scenarios with literal
// expectations, then random bus/pin traffic checked every cycle against a model.
module tb_io_key_dev;
  import io_key_dev_pkg::*;

  localparam int unsigned DBITS  = 16;
  localparam int unsigned DEBCYC = 4;
  localparam int unsigned KBITS  = 4;
  localparam int unsigned SBITS  = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [KBITS-1:0] key;
  logic [SBITS-1:0] sw;
  logic             irq;

  io_key_dev_if #(.DBITS(DBITS)) bus ();

  io_key_dev #(
    .DBITS  (DBITS),
    .DEBCYC (DEBCYC),
    .KBITS  (KBITS),
    .SBITS  (SBITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .key   (key),
    .sw    (sw),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-group view: the pin value seen one and two edges ago, the accepted
  // value, how many edges in a row the synced value has disagreed, and flags.
  typedef struct {
    logic [15:0] deb;
    logic [15:0] h0;
    logic [15:0] h1;
    int          streak;
    bit          rdy;
    bit          ovr;
    bit          ie;
  } grp_t;

  grp_t mk, ms;
  bit   m_irq;

  function automatic grp_t grp_init(logic [15:0] rv);
    grp_t g;
    g.deb = rv; g.h0 = rv; g.h1 = rv; g.streak = 0;
    g.rdy = 1'b0; g.ovr = 1'b0; g.ie = 1'b0;
    return g;
  endfunction

  function automatic grp_t grp_edge(grp_t g, logic [15:0] raw, bit rd_clr,
                                    bit wr, logic [15:0] d);
    grp_t        n;
    bit          chg;
    bit          clr;
    logic [15:0] synced;
    n      = g;
    chg    = 1'b0;
    synced = g.h1;
    n.h1   = g.h0;
    n.h0   = raw;
    if (synced != g.deb) begin
      n.streak = g.streak + 1;
      if (n.streak == int'(DEBCYC)) begin
        n.deb    = synced;
        n.streak = 0;
        chg      = 1'b1;
      end
    end else begin
      n.streak = 0;
    end
    clr   = rd_clr || (wr && !d[0]);
    n.rdy = chg ? 1'b1 : (clr ? 1'b0 : g.rdy);
    if (chg && g.rdy && !clr) n.ovr = 1'b1;
    else if (wr && !d[1])     n.ovr = 1'b0;
    if (wr) n.ie = d[4];
    return n;
  endfunction

  function automatic logic [15:0] ctrl_val(grp_t g);
    logic [15:0] v;
    v    = 16'h0000;
    v[0] = g.rdy;
    v[1] = g.ovr;
    v[4] = g.ie;
    return v;
  endfunction

  function automatic bit is_mapped(logic [15:0] a);
    return (a == IO_KDATA) || (a == IO_SDATA) || (a == IO_KCTRL) || (a == IO_SCTRL);
  endfunction

  function automatic logic [15:0] m_read(logic [15:0] a);
    if (a == IO_KDATA) return mk.deb;
    if (a == IO_SDATA) return ms.deb;
    if (a == IO_KCTRL) return ctrl_val(mk);
    if (a == IO_SCTRL) return ctrl_val(ms);
    return 16'h0000;
  endfunction

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: compare against the model, advance the model, cross the edge.
  task automatic step();
    grp_t nk, ns;
    bit   ni;
    #1;
    chk("sel",  16'(bus.sel), 16'(is_mapped(bus.addr)));
    chk("dout", bus.dout,     m_read(bus.addr));
    chk("irq",  16'(irq),     16'(m_irq));
    if (reset) begin
      nk = grp_init(16'h000F);
      ns = grp_init(16'h0000);
      ni = 1'b0;
    end else begin
      nk = grp_edge(mk, 16'(key), bus.re && (bus.addr == IO_KDATA),
                    bus.we && (bus.addr == IO_KCTRL), bus.din);
      ns = grp_edge(ms, 16'(sw), bus.re && (bus.addr == IO_SDATA),
                    bus.we && (bus.addr == IO_SCTRL), bus.din);
      ni = (mk.rdy && mk.ie) || (ms.rdy && ms.ie);
    end
    @(posedge clk);
    mk    = nk;
    ms    = ns;
    m_irq = ni;
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle();
    bus.addr = 16'h0000; bus.re = 1'b0; bus.we = 1'b0; bus.din = 16'h0000;
  endtask

  task automatic peek(string name, logic [15:0] a, logic [15:0] exp);
    bus.addr = a; bus.re = 1'b0; bus.we = 1'b0;
    #1;
    chk(name, bus.dout, exp);
  endtask

  task automatic wr(logic [15:0] a, logic [15:0] d);
    bus.addr = a; bus.din = d; bus.we = 1'b1; bus.re = 1'b0;
    step();
    idle();
  endtask

  task automatic rd(logic [15:0] a);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    key   = 4'hF;
    sw    = 10'h000;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mk    = grp_init(16'h000F);
    ms    = grp_init(16'h0000);
    m_irq = 1'b0;
    step();
    reset = 1'b0;

    // Reset then idle.
    steps(3);
    peek("rst_kdata", IO_KDATA, 16'h000F);
    peek("rst_sdata", IO_SDATA, 16'h0000);
    step();
    peek("rst_kctrl", IO_KCTRL, 16'h0000);
    peek("rst_sctrl", IO_SCTRL, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    step();

    // Stable key press: accepted at edge 5, irq one edge later.
    wr(IO_KCTRL, 16'h0010);
    key      = 4'hE;
    bus.addr = IO_KCTRL;
    steps(5);
    peek("press_e4_kctrl", IO_KCTRL, 16'h0010);
    step();
    peek("press_e5_kctrl", IO_KCTRL, 16'h0011);
    peek("press_e5_kdata", IO_KDATA, 16'h000E);
    chk("press_e5_irq", 16'(irq), 16'h0000);
    step();
    chk("press_e6_irq", 16'(irq), 16'h0001);

    // Release, clear flags, then bounce key[0] without a stable window.
    rd(IO_KDATA);
    key = 4'hF;
    steps(8);
    wr(IO_KCTRL, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      key[0] = ((i / 2) % 2) != 0;
      peek("bounce_kdata", IO_KDATA, 16'h000F);
      step();
    end
    key = 4'hF;
    steps(8);
    peek("bounce_kctrl", IO_KCTRL, 16'h0010);
    step();

    // Two unread switch changes set OVR; clearing write drops irq.
    wr(IO_SCTRL, 16'h0010);
    sw = 10'h001;
    steps(8);
    sw = 10'h003;
    steps(8);
    peek("sw_sctrl", IO_SCTRL, 16'h0013);
    peek("sw_sdata", IO_SDATA, 16'h0003);
    chk("sw_irq", 16'(irq), 16'h0001);
    bus.addr = IO_SCTRL; bus.din = 16'h0010; bus.we = 1'b1;
    #1;
    chk("sw_wrcyc_old", bus.dout, 16'h0013);
    step();
    idle();
    peek("sw_sctrl_clr", IO_SCTRL, 16'h0010);
    step();
    step();
    chk("sw_irq_drop", 16'(irq), 16'h0000);

    // Read of KDATA coincident with a new key change event.
    key = 4'hE;
    steps(8);
    key = 4'hF;
    steps(5);
    bus.addr = IO_KDATA; bus.re = 1'b1;
    #1;
    chk("coinc_old_kdata", bus.dout, 16'h000E);
    step();
    idle();
    peek("coinc_kctrl", IO_KCTRL, 16'h0011);
    peek("coinc_kdata", IO_KDATA, 16'h000F);
    step();

    // Reset with cnt=2 pending: count restarts from release.
    rd(IO_KDATA);
    key = 4'hE;
    steps(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(5);
    peek("rstmid_r4_kdata", IO_KDATA, 16'h000F);
    step();
    peek("rstmid_r5_kdata", IO_KDATA, 16'h000E);
    peek("rstmid_kctrl", IO_KCTRL, 16'h0001);
    step();
    wr(IO_KDATA, 16'h0000);
    peek("ro_kdata", IO_KDATA, 16'h000E);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel_a;
      int op;
      if ($urandom_range(0, 7) == 0) key = 4'($urandom);
      if ($urandom_range(0, 9) == 0) sw  = 10'($urandom);
      sel_a = int'($urandom_range(0, 4));
      case (sel_a)
        0:       bus.addr = IO_KDATA;
        1:       bus.addr = IO_SDATA;
        2:       bus.addr = IO_KCTRL;
        3:       bus.addr = IO_SCTRL;
        default: bus.addr = 16'($urandom);
      endcase
      op      = int'($urandom_range(0, 7));
      bus.re  = (op < 2);
      bus.we  = (op == 2);
      bus.din = 16'($urandom);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_key_dev.md
# io_key_dev

Memory-mapped responder on the processor's data-memory bus for the KEY and SW inputs, replacing the raw pin pass-through at 0xFFF0/0xFFF2. Each input group is synchronized, debounced and change-captured. A status/control register per group exposes a ready flag, an overrun flag and an interrupt enable. `irq` is intended for the system-register interrupt logic (IE/SIH).

## Interface
- `DBITS`, 16, bus data/address width
- `DEBCYC`, 100000, clock cycles an input must stay stable before it is accepted (≥2)
- `KBITS`, 4, key count
- `SBITS`, 10, switch count
- `clk` in 1: processor clock (PLL output). One clock domain only.
- `reset` in 1: synchronous, active-high.
- `addr` in DBITS: data-memory address (ALU output, M stage).
- `re` in 1: qualified load strobe. High for exactly one cycle per LW.
- `we` in 1: qualified store strobe (wrmem_M).
- `din` in DBITS: store data.
- `dout` out DBITS: combinational read data. 0 when `sel`=0.
- `sel` out 1: combinational; 1 when `addr` is one of the four registers below.
- `key` in KBITS: raw KEY pins, active-low, asynchronous.
- `sw` in SBITS: raw SW pins, asynchronous.
- `irq` out 1: registered interrupt request.

## Operation
- Register map:
  - 0xFFF0 KDATA (RO): debounced keys, zero-extended, pin polarity preserved.
  - 0xFFF2 SDATA (RO): debounced switches, zero-extended.
  - 0xFFF4 KCTRL: bit0 RDY, bit1 OVR, bit4 IE.
  - 0xFFF6 SCTRL: same layout as KCTRL. Unused bits read 0.
- Synchronizer: 2 flops per input bit.
- Debounce, per group:
  - Counter `cnt` clears whenever synced == debounced.
  - When they differ, `cnt` increments.
  - On a cycle where they differ and `cnt`==DEBCYC-1, debounced <= synced and `cnt` <= 0.
  - Any intermediate bounce back to the old value clears `cnt`.
- Change event = debounced register updates this edge.
- RDY:
  - Set by a change event.
  - Cleared by `re` to the matching DATA register.
  - Cleared by `we` to CTRL with din[0]=0. Writing 1 leaves RDY unchanged.
- OVR:
  - Set by a change event while RDY=1 and RDY is not being cleared this cycle.
  - Cleared by `we` to CTRL with din[1]=0.
- IE: loaded from din[4] on any `we` to CTRL.
- Writes to DATA registers are ignored. `re`/`we` to an unmapped address has no effect.
- `irq` <= (KRDY&KIE) | (SRDY&SIE), registered.
- Simultaneous events:
  - Change event and RDY clear (read or write) in the same cycle: RDY ends 1. OVR is not set.
  - Change event and an OVR-clearing write: OVR ends 0 unless the set condition also holds, in which case set wins.
- Reset values:
  - Synchronizers and debounced keys: all 1 (released).
  - Synchronizers and debounced switches: all 0.
  - `cnt` 0; RDY, OVR, IE 0; `irq` 0.
- `dout` and `sel` are combinational and have no reset value.
- Reset mid-debounce discards the pending count. A switch held high at reset produces one change event DEBCYC+1 edges after reset deassertion. This is intended.

## Timing
- Raw change captured at edge 0 and held stable: DATA and RDY update at edge DEBCYC+1. `irq` follows at edge DEBCYC+2.
- Reads: `dout` is valid the same cycle as `addr`. A read side effect (RDY clear) takes effect at the next edge.
- Writes take effect at the next edge. A CTRL read in the write cycle returns the old value.
- Counter width: $clog2(DEBCYC). The counter never wraps, because the saturation compare clears it.

## Structure
- Shared package, used by the CPU top and the bench: address constants IO_KDATA/IO_SDATA/IO_KCTRL/IO_SCTRL, and bit indices CTRL_RDY=0, CTRL_OVR=1, CTRL_IE=4.
- One sub-module, `debounce_sync`, parameterized by WIDTH, DEBCYC and RSTVAL. It contains synchronizer, counter and debounced register, and outputs `level` and a one-cycle `changed` pulse. It is instantiated twice, once for keys and once for switches.
- The top holds the CTRL flags, read mux, `sel` and `irq`.

## Test plan
All tests use DEBCYC=4.
- Reset, then idle: KDATA=0x000F, SDATA=0, KCTRL=SCTRL=0, `irq`=0.
- key=4'b1110 set before edge 0 and held: KDATA=0x000E and KRDY=1 at edge 5. With IE=1 written beforehand, `irq`=1 at edge 6.
- key[0] toggles every 2 cycles for 20 cycles, then held 1: KDATA never shows 0xE. No change event occurs.
- Two stable switch changes (sw=0x001, then sw=0x003) with no read: SCTRL reads 0x13 (IE set). Write SCTRL=0x10: reads 0x10 and `irq` drops the next edge.
- Read KDATA (`re`) on the same cycle a new key change event fires: KRDY stays 1, KOVR stays 0.
- Assert `reset` while `cnt`=2 with a pending key change: after deassertion, the change is accepted only at edge DEBCYC+1 counted from release. `we` to 0xFFF0 leaves KDATA unchanged.
